fifo_pkt_reader: RTL and testbench

Store-and-forward packet drain for the single-clock client FIFO. It pops a length header and waits until the whole packet is resident in the FIFO. It then streams the payload to the downstream transmit client with a valid/ready handshake, one word per clock when ready is held high. It absorbs the FIFO's one-cycle registered read latency with an internal 2-entry skid buffer.

---
 rtl/fifo_pkt_reader.sv | 164 ++++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: drains length-prefixed packets from a single-clock FIFO only once the
// whole packet is resident, streaming the payload through a 2-entry skid buffer.
module fifo_pkt_reader #(
   parameter int dw = 16,
   parameter int aw = 8,
   parameter int lw = aw + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [dw-1:0] fifo_dout,
   input  logic          fifo_empty,
   input  logic          fifo_full,
   input  logic [aw-1:0] fifo_depth,
   output logic          fifo_re,
   output logic [dw-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_first,
   output logic          out_last,
   output logic          busy,
   output logic [15:0]   pkt_count,
   output logic [15:0]   drop_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HDR    = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;
   localparam logic [1:0] STREAM = 2'd3;

   localparam logic [lw-1:0] MAX_LEN = lw'(1) << aw;
   localparam int            EW      = dw + 2;   // skid entry: {last, first, data}

   logic [1:0]    state_reg, state_next;
   logic [lw-1:0] rd_left_reg, rd_left_next;
   logic          first_pend_reg, first_pend_next;
   logic          infl_reg;
   logic          arr_first_reg;
   logic          arr_last_reg;
   logic [1:0]    occ_reg, occ_next;
   logic [15:0]   pkt_count_reg, drop_count_reg;

   logic [lw-1:0] hdr_len;
   logic [lw-1:0] avail;
   logic          stream_re;
   logic          pop;
   logic          last_pop;
   logic          hdr_drop;
   logic [EW-1:0] arr_word;
   logic [EW-1:0] head;
   logic [EW-1:0] skid_word [2];
   logic [EW-1:0] cand [3];

   assign hdr_len  = fifo_dout[lw-1:0];
   // Depth wraps to 0 when the FIFO is full, so full has to be folded back in.
   assign avail    = fifo_full ? MAX_LEN : lw'(fifo_depth);
   assign hdr_drop = (state_reg == HDR) && (hdr_len == '0);

   // The word returning from the FIFO this cycle is visible at the head when the skid is empty.
   assign arr_word = {arr_last_reg, arr_first_reg, fifo_dout};
   assign head     = (occ_reg == 2'd0) ? arr_word : skid_word[0];

   assign out_valid = (occ_reg != 2'd0) || infl_reg;
   assign out_data  = out_valid ? head[dw-1:0] : '0;
   assign out_first = out_valid & head[dw];
   assign out_last  = out_valid & head[dw+1];
   assign pop       = out_valid & out_ready;
   assign last_pop  = pop & head[dw+1];

   assign busy       = (state_reg != IDLE) || (occ_reg != 2'd0);
   assign pkt_count  = pkt_count_reg;
   assign drop_count = drop_count_reg;

   always_comb begin
      fifo_re   = 1'b0;
      stream_re = 1'b0;
      case (state_reg)
         IDLE: fifo_re = !fifo_empty;
         STREAM: begin
            stream_re = (rd_left_reg != '0) &&
                        (({1'b0, occ_reg} + {2'b00, infl_reg}) < (3'd2 + {2'b00, pop}));
            fifo_re   = stream_re;
         end
         default: ;
      endcase
      if (!rst_n) begin
         fifo_re   = 1'b0;
         stream_re = 1'b0;
      end
   end

   always_comb begin
      state_next      = state_reg;
      rd_left_next    = rd_left_reg;
      first_pend_next = first_pend_reg;
      case (state_reg)
         IDLE: begin
            if (fifo_re) state_next = HDR;
         end
         HDR: begin
            if (hdr_len == '0) begin
               state_next = IDLE;
            end else begin
               rd_left_next    = (hdr_len > MAX_LEN) ? MAX_LEN : hdr_len;
               first_pend_next = 1'b1;
               state_next      = WAIT;
            end
         end
         WAIT: begin
            if (avail >= rd_left_reg) state_next = STREAM;
         end
         STREAM: begin
            if (stream_re) begin
               rd_left_next    = rd_left_reg - lw'(1);
               first_pend_next = 1'b0;
            end
            if (last_pop) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Candidate list: stored entries in order, then the arriving word; a pop shifts it by one.
   assign cand[0]  = (occ_reg != 2'd0) ? skid_word[0] : arr_word;
   assign cand[1]  = (occ_reg == 2'd2) ? skid_word[1] : arr_word;
   assign cand[2]  = arr_word;
   assign occ_next = occ_reg + {1'b0, infl_reg} - {1'b0, pop};

   for (genvar gi = 0; gi < 2; gi++) begin : g_skid
      logic [EW-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            entry_reg <= '0;
         end else begin
            entry_reg <= pop ? cand[gi+1] : cand[gi];
         end
      end
      assign skid_word[gi] = entry_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         rd_left_reg    <= '0;
         first_pend_reg <= 1'b0;
         infl_reg       <= 1'b0;
         arr_first_reg  <= 1'b0;
         arr_last_reg   <= 1'b0;
         occ_reg        <= 2'd0;
         pkt_count_reg  <= '0;
         drop_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         rd_left_reg    <= rd_left_next;
         first_pend_reg <= first_pend_next;
         infl_reg       <= stream_re;
         arr_first_reg  <= stream_re & first_pend_reg;
         arr_last_reg   <= stream_re & (rd_left_reg == lw'(1));
         occ_reg        <= occ_next;
         if (last_pop) pkt_count_reg  <= pkt_count_reg + 16'd1;
         if (hdr_drop) drop_count_reg <= drop_count_reg + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: behavioural 16-word FIFO, directed packets, and a scoreboard
// monitor that checks every accepted output word against the expected queue.
module tb_fifo_pkt_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_full;
   logic [3:0]  fifo_depth;
   logic        fifo_re;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_first;
   logic        out_last;
   logic        busy;
   logic [15:0] pkt_count;
   logic [15:0] drop_count;

   logic        wr_en;
   logic [15:0] wr_data;
   logic        fifo_clr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int exp_pkt  = 0;
   int exp_drop = 0;

   typedef struct {
      logic [15:0] d;
      logic        f;
      logic        l;
      int          c;
   } exp_t;
   exp_t sb[$];

   fifo_pkt_reader #(.dw(16), .aw(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .fifo_depth (fifo_depth),
      .fifo_re    (fifo_re),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_first  (out_first),
      .out_last   (out_last),
      .busy       (busy),
      .pkt_count  (pkt_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-clock FIFO model with registered read data and a 16-word capacity.
   logic [15:0] fmem [16];
   logic [3:0]  wp, rp;
   logic [4:0]  cnt;
   logic        rd_ok, wr_ok;

   assign rd_ok      = fifo_re && (cnt != 5'd0);
   assign wr_ok      = wr_en && ((cnt != 5'd16) || rd_ok);
   assign fifo_empty = (cnt == 5'd0);
   assign fifo_full  = (cnt == 5'd16);
   assign fifo_depth = cnt[3:0];

   always @(posedge clk) begin
      if (fifo_clr) begin
         wp        <= 4'd0;
         rp        <= 4'd0;
         cnt       <= 5'd0;
         fifo_dout <= 16'd0;
      end else begin
         if (rd_ok) begin
            fifo_dout <= fmem[rp];
            rp        <= rp + 4'd1;
         end
         if (wr_ok) begin
            fmem[wp] <= wr_data;
            wp       <= wp + 4'd1;
         end
         cnt <= cnt + {4'd0, wr_ok} - {4'd0, rd_ok};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic exp_word(input logic [15:0] d, input logic f, input logic l, input int c);
      exp_t e;
      e.d = d;
      e.f = f;
      e.l = l;
      e.c = c;
      sb.push_back(e);
   endtask

   task automatic hold_and_flush();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      exp_pkt   = 0;
      exp_drop  = 0;
      fifo_clr  = 1'b1;
      tick();
      fifo_clr  = 1'b0;
   endtask

   task automatic drain(input string name, input int limit);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < limit) begin
         tick();
         n++;
      end
      if (n >= limit) begin
         checks++;
         failures++;
         $display("FAIL %s timeout actual=%0d pending words required=0", name, sb.size());
      end
   endtask

   task automatic check_counts(input string name);
      check({name, "_pkt"}, 32'(pkt_count), 32'(exp_pkt));
      check({name, "_drop"}, 32'(drop_count), 32'(exp_drop));
   endtask

   // Scoreboard monitor: compares every accepted word, and holds data stable across stalls.
   initial begin : monitor
      logic        prev_stall;
      logic [15:0] prev_data;
      exp_t        e;
      prev_stall = 1'b0;
      prev_data  = 16'd0;
      forever begin
         @(negedge clk);
         if (fifo_re) check("re_not_empty", 32'(fifo_empty), 32'd0);
         if (prev_stall && rst_n) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word actual=%h required=none (cyc %0d)", out_data, cyc);
            end else begin
               e = sb.pop_front();
               $display("xfer cyc=%0d data=%h first=%b last=%b", cyc, out_data, out_first, out_last);
               check("word_data", 32'(out_data), 32'(e.d));
               check("word_first", 32'(out_first), 32'(e.f));
               check("word_last", 32'(out_last), 32'(e.l));
               if (e.c >= 0) check("word_cycle", 32'(cyc), 32'(e.c));
            end
         end
         prev_stall = out_valid && !out_ready && rst_n;
         prev_data  = out_data;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int         t0, h, k;
      logic [5:0] bp_pat;
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_data   = 16'd0;
      fifo_clr  = 1'b1;
      out_ready = 1'b1;
      bp_pat    = 6'b101001;
      tick();

      // Single 4-word packet, pre-loaded, plus reset-state checks with a non-empty FIFO.
      hold_and_flush();
      wr(16'd4);
      for (int i = 0; i < 4; i++) wr(16'hA000 + 16'(i));
      tick();
      check("rst_fifo_re", 32'(fifo_re), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_first_last", 32'({out_first, out_last}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_counts("rst");
      rst_n = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 4; i++) exp_word(16'hA000 + 16'(i), i == 0, i == 3, t0 + 4 + i);
      drain("single", 50);
      exp_pkt++;
      check_counts("single");

      // Store-and-forward: header 8, payload trickles in one word per 3 cycles.
      h = cyc;
      for (int i = 0; i < 8; i++) exp_word(16'hB000 + 16'(i), i == 0, i == 7, h + 27 + i);
      wr_en = 1'b1;
      wr_data = 16'd8;
      tick();
      wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         tick();
         wr_en   = 1'b1;
         wr_data = 16'hB000 + 16'(i);
         tick();
         wr_en   = 1'b0;
      end
      drain("saf", 80);
      exp_pkt++;
      check_counts("saf");

      // Backpressure: 6-word packet with out_ready cycling 1,0,0,1,0,1.
      for (int i = 0; i < 6; i++) exp_word(16'hC000 + 16'(i), i == 0, i == 5, -1);
      k = 0;
      while (k < 200 && !(k > 7 && sb.size() == 0 && !busy)) begin
         out_ready = bp_pat[k % 6];
         if (k == 0) begin
            wr_en   = 1'b1;
            wr_data = 16'd6;
         end else if (k <= 6) begin
            wr_en   = 1'b1;
            wr_data = 16'hC000 + 16'(k - 1);
         end else begin
            wr_en = 1'b0;
         end
         tick();
         k++;
      end
      wr_en     = 1'b0;
      out_ready = 1'b1;
      if (k >= 200) begin
         checks++;
         failures++;
         $display("FAIL backpressure timeout actual=%0d pending words required=0", sb.size());
      end
      exp_pkt++;
      check_counts("bp");

      // Back-to-back packets of 3, 1 and 5 words, all resident.
      hold_and_flush();
      wr(16'd3);
      for (int i = 0; i < 3; i++) wr(16'hD000 + 16'(i));
      wr(16'd1);
      wr(16'hD100);
      wr(16'd5);
      for (int i = 0; i < 5; i++) wr(16'hD200 + 16'(i));
      rst_n = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 3; i++) exp_word(16'hD000 + 16'(i), i == 0, i == 2, t0 + 4 + i);
      exp_word(16'hD100, 1'b1, 1'b1, t0 + 11);
      for (int i = 0; i < 5; i++) exp_word(16'hD200 + 16'(i), i == 0, i == 4, t0 + 16 + i);
      drain("b2b", 80);
      exp_pkt += 3;
      check_counts("b2b");

      // Zero-length header is dropped, then a 1-word packet carries both markers.
      hold_and_flush();
      wr(16'd0);
      wr(16'd1);
      wr(16'hBEEF);
      rst_n = 1'b1;
      t0 = cyc;
      exp_word(16'hBEEF, 1'b1, 1'b1, t0 + 6);
      drain("drop", 50);
      exp_pkt++;
      exp_drop++;
      check_counts("drop");

      // Header with high junk bits and length 20 saturates to 16; FIFO fills, depth reads 0.
      h = cyc;
      for (int i = 0; i < 16; i++) exp_word(16'hE000 + 16'(i), i == 0, i == 15, h + 19 + i);
      wr(16'hAB14);
      for (int i = 0; i < 16; i++) wr(16'hE000 + 16'(i));
      drain("full", 80);
      exp_pkt++;
      check_counts("full");

      // Reset asserted while the third word of a 5-word packet is presented.
      h = cyc;
      exp_word(16'hF000, 1'b1, 1'b0, h + 8);
      exp_word(16'hF001, 1'b0, 1'b0, h + 9);
      wr(16'd5);
      for (int i = 0; i < 5; i++) wr(16'hF000 + 16'(i));
      k = 0;
      while (cyc < h + 10 && k < 50) begin
         tick();
         k++;
      end
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n    = 1'b0;
      exp_pkt  = 0;
      exp_drop = 0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data", 32'(out_data), 32'd0);
      check("arst_first_last", 32'({out_first, out_last}), 32'd0);
      check("arst_fifo_re", 32'(fifo_re), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check_counts("arst");

      // Recovery after flush: a fresh 2-word packet is delivered normally.
      hold_and_flush();
      wr(16'd2);
      wr(16'h1234);
      wr(16'h5678);
      rst_n = 1'b1;
      t0 = cyc;
      exp_word(16'h1234, 1'b1, 1'b0, t0 + 4);
      exp_word(16'h5678, 1'b0, 1'b1, t0 + 5);
      drain("recover", 50);
      exp_pkt++;
      check_counts("recover");
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
